axi4lite_req_arbiter: RTL and testbench

AXI4LITE_REQ_ARBITER -- requirements
Module: axi4lite_req_arbiter

---
 rtl/axi4lite_req_arbiter_if.sv | 48 ++++
 rtl/axi4lite_req_arbiter.sv | 130 +++++++++++++
 tb/tb_axi4lite_req_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_req_arbiter_if.sv
// Bundle of requester and master-port signals for axi4lite_req_arbiter.
// The "slave" modport is the arbiter's own view: it serves both requesters and
// drives the master user port. The "master" modport is the surrounding
// environment's view, which drives requests and master responses.
interface axi4lite_req_arbiter_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  err0;
    logic                  err1;
    logic                  m_start_write;
    logic                  m_start_read;
    logic [ADDR_WIDTH-1:0] m_write_addr;
    logic [ADDR_WIDTH-1:0] m_read_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_read_data;
    logic                  m_done;
    logic                  busy;
    logic                  grant_id;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  m_read_data, m_done,
        output ack0, ack1, rdata0, rdata1, err0, err1,
        output m_start_write, m_start_read, m_write_addr, m_read_addr, m_wdata,
        output busy, grant_id
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output m_read_data, m_done,
        input  ack0, ack1, rdata0, rdata1, err0, err1,
        input  m_start_write, m_start_read, m_write_addr, m_read_addr, m_wdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/axi4lite_req_arbiter.sv
// Two-requester round-robin arbiter in front of an AXI4-Lite master user port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with a
// timeout that completes the transaction with an error if m_done never comes.
// All outputs decode from registered state and latched operands only.
module axi4lite_req_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4lite_req_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // The counter holds completed WAIT cycles; the TIMEOUT-th WAIT cycle is
    // the one that sees CNT_LAST, so m_done in that same cycle still wins.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  gid_q, gid_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  sel;
    logic                  in_issue;
    logic                  in_resp;

    // Next-state, arbitration and operand capture.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        sel     = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gid_d   = sel;
                    we_d    = sel ? bus.we1    : bus.we0;
                    addr_d  = sel ? bus.addr1  : bus.addr0;
                    wdata_d = sel ? bus.wdata1 : bus.wdata0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.m_done) begin
                    rdata_d = we_q ? '0 : bus.m_read_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                ptr_d   = ~gid_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and operand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            gid_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign in_issue = (state_q == S_ISSUE);
    assign in_resp  = (state_q == S_RESP);

    assign bus.m_start_write = in_issue &  we_q;
    assign bus.m_start_read  = in_issue & ~we_q;
    assign bus.m_write_addr  = addr_q;
    assign bus.m_read_addr   = addr_q;
    assign bus.m_wdata       = wdata_q;

    assign bus.ack0   = in_resp & ~gid_q;
    assign bus.ack1   = in_resp &  gid_q;
    assign bus.rdata0 = (in_resp && !gid_q) ? rdata_q : '0;
    assign bus.rdata1 = (in_resp &&  gid_q) ? rdata_q : '0;
    assign bus.err0   = in_resp & ~gid_q & err_q;
    assign bus.err1   = in_resp &  gid_q & err_q;

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.grant_id = gid_q;

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Self-checking bench for axi4lite_req_arbiter: a transaction-timing model
// predicts every output each cycle, plus directed scenarios with literal values.
module tb_axi4lite_req_arbiter;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi4lite_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timing model: a transaction granted at edge g shows its strobe after
    // edge g, samples m_done at edges g+2 onward (wait cycle n = cyc-g-1),
    // and acks in the cycle after the resolving edge r.
    int          cyc = 0;
    bit          started = 0;
    bit          m_act, m_res, m_own, m_ptr, m_we, m_err;
    int          m_g, m_r;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started = 1;
            m_act = 0; m_res = 0; m_own = 0; m_ptr = 0; m_we = 0; m_err = 0;
            m_addr = '0; m_wd = '0; m_rd = '0;
        end else if (!m_act) begin
            if (bus.req0 || bus.req1) begin
                m_own  = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
                m_we   = m_own ? bus.we1 : bus.we0;
                m_addr = m_own ? bus.addr1 : bus.addr0;
                m_wd   = m_own ? bus.wdata1 : bus.wdata0;
                m_act  = 1; m_res = 0; m_g = cyc;
            end
        end else if (!m_res) begin
            if (cyc >= m_g + 2) begin
                if (bus.m_done) begin
                    m_res = 1; m_r = cyc; m_err = 0;
                    m_rd  = m_we ? '0 : bus.m_read_data;
                end else if (cyc - (m_g + 1) == TO) begin
                    m_res = 1; m_r = cyc; m_err = 1; m_rd = '0;
                end
            end
        end else if (cyc == m_r + 1) begin
            m_act = 0;
            m_ptr = !m_own;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (started) begin
            logic issue, resp;
            issue = m_act && (cyc == m_g);
            resp  = m_act && m_res && (cyc == m_r);
            chk("busy",     bus.busy,          m_act);
            chk("swrite",   bus.m_start_write, issue && m_we);
            chk("sread",    bus.m_start_read,  issue && !m_we);
            chk("waddr",    bus.m_write_addr,  m_addr);
            chk("raddr",    bus.m_read_addr,   m_addr);
            chk("wdata",    bus.m_wdata,       m_wd);
            chk("grant",    bus.grant_id,      m_own);
            chk("ack0",     bus.ack0,          resp && !m_own);
            chk("ack1",     bus.ack1,          resp && m_own);
            chk("rdata0",   bus.rdata0,        (resp && !m_own) ? m_rd : '0);
            chk("rdata1",   bus.rdata1,        (resp && m_own) ? m_rd : '0);
            chk("err0",     bus.err0,          resp && !m_own && m_err);
            chk("err1",     bus.err1,          resp && m_own && m_err);
        end
    end

    initial begin
        int pct_tab [4] = '{30, 0, 70, 10};
        int n;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.m_read_data = '0; bus.m_done = 0;

        // Reset state
        rst = 1; tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", {bus.ack0, bus.ack1}, 0);
        chk("rst_strobes", {bus.m_start_write, bus.m_start_read}, 0);
        chk("rst_grant", bus.grant_id, 0);
        rst = 0;

        // Single write from requester 0
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 2; bus.wdata0 = 8'hA5;
        tick();
        chk("wr_start", bus.m_start_write, 1);
        chk("wr_noread", bus.m_start_read, 0);
        chk("wr_addr", bus.m_write_addr, 2);
        chk("wr_data", bus.m_wdata, 8'hA5);
        chk("wr_grant", bus.grant_id, 0);
        tick();
        chk("wr_start_one_cycle", bus.m_start_write, 0);
        bus.m_done = 1; tick(); bus.m_done = 0;
        chk("wr_ack0", bus.ack0, 1);
        chk("wr_err0", bus.err0, 0);
        chk("wr_ack1", bus.ack1, 0);
        bus.req0 = 0; tick();
        chk("wr_ack_one_cycle", bus.ack0, 0);

        // Single read from requester 1
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 1;
        tick();
        chk("rd_start", bus.m_start_read, 1);
        chk("rd_addr", bus.m_read_addr, 1);
        tick();
        bus.m_read_data = 8'h3C; bus.m_done = 1; tick(); bus.m_done = 0;
        chk("rd_ack1", bus.ack1, 1);
        chk("rd_data1", bus.rdata1, 8'h3C);
        chk("rd_grant", bus.grant_id, 1);
        bus.req1 = 0; tick();

        // Timeout on a read from requester 0
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3; bus.m_read_data = 8'hFF;
        tick(); tick();
        repeat (TO - 1) tick();
        chk("to_not_early", bus.ack0, 0);
        tick();
        chk("to_ack0", bus.ack0, 1);
        chk("to_err0", bus.err0, 1);
        chk("to_rdata0", bus.rdata0, 0);
        bus.req0 = 0; tick();

        // m_done in the same WAIT cycle as the timeout
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 0;
        tick(); tick();
        repeat (TO - 1) tick();
        bus.m_done = 1; bus.m_read_data = 8'h5A; tick(); bus.m_done = 0;
        chk("co_ack1", bus.ack1, 1);
        chk("co_err1", bus.err1, 0);
        chk("co_rdata1", bus.rdata1, 8'h5A);
        bus.req1 = 0; tick();

        // Stray m_done in IDLE
        bus.m_done = 1; tick(); bus.m_done = 0;
        chk("stray_busy", bus.busy, 0);
        chk("stray_ack", {bus.ack0, bus.ack1}, 0);
        tick();
        chk("stray_busy2", bus.busy, 0);

        // Contention after reset: grants alternate 0,1,0,1
        rst = 1; tick(); rst = 0;
        bus.req0 = 1; bus.req1 = 1; bus.we0 = 1; bus.we1 = 1;
        bus.addr0 = 1; bus.addr1 = 2; bus.wdata0 = 8'h11; bus.wdata1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(bus.m_start_write || bus.m_start_read) && n < 20) begin
                tick(); n++;
            end
            chk("cont_grant_seen", bus.m_start_write, 1);
            chk("cont_grant_id", bus.grant_id, k % 2);
            tick();
            bus.m_done = 1; tick(); bus.m_done = 0;
            chk("cont_ack0", bus.ack0, (k % 2) == 0);
            chk("cont_ack1", bus.ack1, (k % 2) == 1);
        end
        bus.req0 = 0; bus.req1 = 0; tick(); tick();

        // Reset during WAIT: pointer was 1 after requester 0 completes
        bus.req0 = 1; tick(); tick();
        bus.m_done = 1; tick(); bus.m_done = 0; bus.req0 = 0; tick();
        bus.req1 = 1; bus.we1 = 0; tick(); tick();
        rst = 1; tick(); rst = 0; bus.req1 = 0;
        chk("rw_busy", bus.busy, 0);
        chk("rw_ack", {bus.ack0, bus.ack1}, 0);
        chk("rw_strobes", {bus.m_start_write, bus.m_start_read}, 0);
        chk("rw_addr", bus.m_read_addr, 0);
        chk("rw_wdata", bus.m_wdata, 0);
        bus.m_done = 1; tick(); bus.m_done = 0;
        chk("rw_late_done", {bus.ack0, bus.ack1, bus.busy}, 0);
        bus.req0 = 1; bus.req1 = 1; tick();
        chk("rw_ptr_reset", bus.grant_id, 0);
        tick(); bus.m_done = 1; tick(); bus.m_done = 0;
        bus.req0 = 0; bus.req1 = 0; tick(); tick();

        // Randomized traffic with varying master responsiveness
        for (int b = 0; b < 4; b++) begin
            repeat (500) begin
                tick();
                rst = ($urandom % 300) == 0;
                bus.m_done = ($urandom % 100) < pct_tab[b];
                bus.m_read_data = DW'($urandom);
                if (bus.req0) begin
                    if (bus.ack0 || (bus.busy && !bus.grant_id && ($urandom % 16) == 0))
                        bus.req0 = 0;
                end else if (($urandom % 3) == 0) begin
                    bus.req0 = 1; bus.we0 = $urandom % 2;
                    bus.addr0 = AW'($urandom); bus.wdata0 = DW'($urandom);
                end
                if (bus.req1) begin
                    if (bus.ack1 || (bus.busy && bus.grant_id && ($urandom % 16) == 0))
                        bus.req1 = 0;
                end else if (($urandom % 3) == 0) begin
                    bus.req1 = 1; bus.we1 = $urandom % 2;
                    bus.addr1 = AW'($urandom); bus.wdata1 = DW'($urandom);
                end
            end
        end
        rst = 0; bus.req0 = 0; bus.req1 = 0; bus.m_done = 0;
        repeat (TO + 8) tick();
        chk("drain_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
